// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory arbiter between the IF and M stages.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_IF,
        BUSY_DM
    } arb_state_t;

    typedef enum logic {
        OWN_IF,
        OWN_DM
    } owner_t;

    localparam int CNT_W = 4;

endpackage

// File: rtl/arb_latency_counter.sv
// Loadable down-counter; done is high whenever the count has reached zero.
module arb_latency_counter
    import mem_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Serialises IF and M accesses onto one fixed-latency memory port and drives the pipeline stalls.
//   state   | meaning
//   IDLE    | no access outstanding; any pending request issues this cycle
//   BUSY_IF | fetch outstanding, waiting for the latency counter
//   BUSY_DM | data access outstanding, waiting for the latency counter
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int MEM_LATENCY   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     if_req,
    input  logic [ADDRESS_WIDTH-1:0] if_addr,
    output logic [DATA_WIDTH-1:0]    if_rdata,
    output logic                     if_valid,
    input  logic                     dm_req,
    input  logic                     dm_we,
    input  logic [ADDRESS_WIDTH-1:0] dm_addr,
    input  logic [DATA_WIDTH-1:0]    dm_wdata,
    output logic [DATA_WIDTH-1:0]    dm_rdata,
    output logic                     dm_valid,
    output logic                     stall_if,
    output logic                     stall_m,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic [DATA_WIDTH-1:0]    mem_rdata
);

    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(MEM_LATENCY - 1);

    arb_state_t            state, state_nxt;
    owner_t                last_grant, winner;
    logic                  issue, issue_we, cur_we, cnt_done;
    logic                  if_done, dm_done;
    logic [DATA_WIDTH-1:0] if_hold, dm_hold;

    // On a tie the requester that was not served last time goes first.
    always_comb begin
        winner = OWN_IF;
        if (dm_req && (!if_req || last_grant == OWN_IF)) begin
            winner = OWN_DM;
        end
    end

    assign issue    = (state == IDLE) && (if_req || dm_req);
    assign issue_we = (winner == OWN_DM) && dm_we;

    arb_latency_counter u_lat_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (issue),
        .load_val (issue_we ? '0 : RD_LOAD),
        .done     (cnt_done)
    );

    always_comb begin
        state_nxt = state;
        if_done   = 1'b0;
        dm_done   = 1'b0;
        case (state)
            IDLE: begin
                if (issue) begin
                    state_nxt = (winner == OWN_DM) ? BUSY_DM : BUSY_IF;
                end
            end
            BUSY_IF: begin
                if (cnt_done) begin
                    if_done   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            BUSY_DM: begin
                if (cnt_done) begin
                    dm_done   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            last_grant <= OWN_IF;
            cur_we     <= 1'b0;
            if_hold    <= '0;
            dm_hold    <= '0;
        end else begin
            state <= state_nxt;
            if (issue) begin
                last_grant <= winner;
                cur_we     <= issue_we;
            end
            if (if_done) begin
                if_hold <= mem_rdata;
            end
            if (dm_done && !cur_we) begin
                dm_hold <= mem_rdata;
            end
        end
    end

    // Strobes, pulses and stalls are gated by rst so they drop the moment reset asserts.
    assign mem_en    = rst && issue;
    assign mem_we    = rst && issue && issue_we;
    assign mem_addr  = (rst && issue) ? ((winner == OWN_DM) ? dm_addr : if_addr) : '0;
    assign mem_wdata = (rst && issue && issue_we) ? dm_wdata : '0;

    assign if_valid = rst && if_done;
    assign dm_valid = rst && dm_done;
    assign if_rdata = if_valid ? mem_rdata : if_hold;
    assign dm_rdata = (dm_valid && !cur_we) ? mem_rdata : dm_hold;

    assign stall_if = rst && if_req && !if_valid;
    assign stall_m  = rst && dm_req && !dm_valid;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: instance 0 runs MEM_LATENCY=2, instance 1 runs MEM_LATENCY=1.
module tb_mem_arbiter;

    localparam logic [31:0] INS  = 32'h0050_0093;
    localparam logic [31:0] BEEF = 32'hDEAD_BEEF;

    typedef struct {
        logic        ifr;
        logic [31:0] ifa;
        logic        dmr;
        logic        dmw;
        logic [31:0] dma;
        logic [31:0] dmd;
        logic        en;
        logic        we;
        logic [31:0] addr;
        logic        ifv;
        logic [31:0] ifd;
        logic        dmv;
        logic [31:0] dmdat;
        logic        sif;
        logic        sm;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst [2];
    logic        if_req [2];
    logic [31:0] if_addr [2];
    logic [31:0] if_rdata [2];
    logic        if_valid [2];
    logic        dm_req [2];
    logic        dm_we [2];
    logic [31:0] dm_addr [2];
    logic [31:0] dm_wdata [2];
    logic [31:0] dm_rdata [2];
    logic        dm_valid [2];
    logic        stall_if [2];
    logic        stall_m [2];
    logic        mem_en [2];
    logic        mem_we [2];
    logic [31:0] mem_addr [2];
    logic [31:0] mem_wdata [2];
    logic [31:0] mem_rdata [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_arbiter #(
            .ADDRESS_WIDTH (32),
            .DATA_WIDTH    (32),
            .MEM_LATENCY   ((g == 0) ? 2 : 1)
        ) u_dut (
            .clk       (clk),
            .rst       (rst[g]),
            .if_req    (if_req[g]),
            .if_addr   (if_addr[g]),
            .if_rdata  (if_rdata[g]),
            .if_valid  (if_valid[g]),
            .dm_req    (dm_req[g]),
            .dm_we     (dm_we[g]),
            .dm_addr   (dm_addr[g]),
            .dm_wdata  (dm_wdata[g]),
            .dm_rdata  (dm_rdata[g]),
            .dm_valid  (dm_valid[g]),
            .stall_if  (stall_if[g]),
            .stall_m   (stall_m[g]),
            .mem_en    (mem_en[g]),
            .mem_we    (mem_we[g]),
            .mem_addr  (mem_addr[g]),
            .mem_wdata (mem_wdata[g]),
            .mem_rdata (mem_rdata[g])
        );
    end

    // Memory environment: writes commit at the issue edge, read data appears exactly
    // MEM_LATENCY cycles after issue and is random noise in every other cycle.
    logic [31:0] env_mem [2][256];
    logic [31:0] rd_dat [2];
    int          rd_rem [2];
    bit          env_ready = 1'b0;

    always @(posedge clk) begin
        if (!env_ready) begin
            for (int u = 0; u < 2; u++) begin
                for (int i = 0; i < 256; i++) env_mem[u][i] = $urandom;
                rd_rem[u] = -1;
                rd_dat[u] = '0;
            end
            env_mem[0][4] = INS;
            env_mem[1][0] = 32'h0000_0013;
            env_mem[1][1] = 32'h0040_0113;
            env_ready = 1'b1;
        end
        for (int u = 0; u < 2; u++) begin
            if (rd_rem[u] >= 0) rd_rem[u] = rd_rem[u] - 1;
            if (mem_en[u] === 1'b1) begin
                if (mem_we[u]) begin
                    env_mem[u][mem_addr[u][9:2]] = mem_wdata[u];
                end else begin
                    rd_dat[u] = env_mem[u][mem_addr[u][9:2]];
                    rd_rem[u] = (u == 0) ? 1 : 0;
                end
            end
            mem_rdata[u] <= (rd_rem[u] == 0) ? rd_dat[u] : $urandom;
        end
    end

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_zero(input int u, input string nm);
        chk1({nm, " mem_en"}, mem_en[u], 1'b0);
        chk1({nm, " mem_we"}, mem_we[u], 1'b0);
        chk1({nm, " if_valid"}, if_valid[u], 1'b0);
        chk1({nm, " dm_valid"}, dm_valid[u], 1'b0);
        chk1({nm, " stall_if"}, stall_if[u], 1'b0);
        chk1({nm, " stall_m"}, stall_m[u], 1'b0);
        chk32({nm, " mem_addr"}, mem_addr[u], 32'h0);
        chk32({nm, " if_rdata"}, if_rdata[u], 32'h0);
        chk32({nm, " dm_rdata"}, dm_rdata[u], 32'h0);
    endtask

    function automatic vec_t v(input logic ifr, input logic [31:0] ifa, input logic dmr,
                               input logic dmw, input logic [31:0] dma, input logic [31:0] dmd,
                               input logic en, input logic we, input logic [31:0] addr,
                               input logic ifv, input logic [31:0] ifd, input logic dmv,
                               input logic [31:0] dmdat, input logic sif, input logic sm);
        vec_t r;
        r.ifr = ifr; r.ifa = ifa; r.dmr = dmr; r.dmw = dmw; r.dma = dma; r.dmd = dmd;
        r.en = en; r.we = we; r.addr = addr; r.ifv = ifv; r.ifd = ifd;
        r.dmv = dmv; r.dmdat = dmdat; r.sif = sif; r.sm = sm;
        return r;
    endfunction

    // Reference model works on transactions: who wins, in which cycle it completes,
    // and what data a completed read must return from a shadow memory.
    logic [31:0] ref_mem [256];

    task automatic run_random(input int u, input int n);
        int          lat, done_cyc;
        bit          busy, own_dm, rd, last_dm, pick_dm, prev_ifv, prev_dmv;
        logic        e_en, e_we, e_ifv, e_dmv;
        logic [31:0] exp_data, hold_if, hold_dm, e_addr, e_wd;
        lat = (u == 0) ? 2 : 1;
        @(negedge clk);
        rst[u] = 1'b0; if_req[u] = 1'b0; dm_req[u] = 1'b0;
        #1 chk_zero(u, "rnd reset");
        @(negedge clk);
        rst[u] = 1'b1;
        for (int i = 0; i < 256; i++) ref_mem[i] = env_mem[u][i];
        busy = 0; own_dm = 0; rd = 0; last_dm = 0; prev_ifv = 0; prev_dmv = 0; done_cyc = 0;
        exp_data = '0; hold_if = '0; hold_dm = '0;
        for (int c = 0; c < n; c++) begin
            if (c > 0) @(negedge clk);
            if (!if_req[u] || prev_ifv) begin
                if_req[u]  = ($urandom_range(1, 0) == 1);
                if_addr[u] = $urandom_range(15, 0) << 2;
            end else if ($urandom_range(15, 0) == 0) begin
                if_req[u] = 1'b0;
            end
            if (!dm_req[u] || prev_dmv) begin
                dm_req[u]   = ($urandom_range(1, 0) == 1);
                dm_we[u]    = 1'($urandom_range(1, 0));
                dm_addr[u]  = $urandom_range(15, 0) << 2;
                dm_wdata[u] = $urandom;
            end else if ($urandom_range(15, 0) == 0) begin
                dm_req[u] = 1'b0;
            end
            #1;
            e_en = 0; e_we = 0; e_ifv = 0; e_dmv = 0; e_addr = '0; e_wd = '0;
            if (!busy) begin
                if (if_req[u] || dm_req[u]) begin
                    pick_dm  = dm_req[u] && (!if_req[u] || !last_dm);
                    e_en     = 1'b1;
                    e_we     = pick_dm && dm_we[u];
                    e_addr   = pick_dm ? dm_addr[u] : if_addr[u];
                    e_wd     = dm_wdata[u];
                    busy     = 1;
                    own_dm   = pick_dm;
                    last_dm  = pick_dm;
                    rd       = !e_we;
                    done_cyc = c + (rd ? lat : 1);
                    if (rd) exp_data = ref_mem[e_addr[9:2]];
                    else    ref_mem[e_addr[9:2]] = e_wd;
                end
            end else if (c == done_cyc) begin
                if (own_dm) e_dmv = 1'b1;
                else        e_ifv = 1'b1;
                if (rd) begin
                    if (own_dm) hold_dm = exp_data;
                    else        hold_if = exp_data;
                end
                busy = 0;
            end
            chk1("rnd mem_en", mem_en[u], e_en);
            if (e_en) begin
                chk32("rnd mem_addr", mem_addr[u], e_addr);
                chk1("rnd mem_we", mem_we[u], e_we);
                if (e_we) chk32("rnd mem_wdata", mem_wdata[u], e_wd);
            end
            chk1("rnd if_valid", if_valid[u], e_ifv);
            chk1("rnd dm_valid", dm_valid[u], e_dmv);
            chk32("rnd if_rdata", if_rdata[u], hold_if);
            chk32("rnd dm_rdata", dm_rdata[u], hold_dm);
            chk1("rnd stall_if", stall_if[u], if_req[u] && !e_ifv);
            chk1("rnd stall_m", stall_m[u], dm_req[u] && !e_dmv);
            prev_ifv = e_ifv;
            prev_dmv = e_dmv;
        end
        @(negedge clk);
        if_req[u] = 1'b0; dm_req[u] = 1'b0;
    endtask

    initial begin
        vec_t        vt [10];
        logic [31:0] order [$];
        int          run_if, run_dm, max_if, max_dm;

        // fields: ifr ifa dmr dmw dma dmd | en we addr ifv ifd dmv dmdat sif sm
        vt[0] = v(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0,   1'b1, 1'b0, 32'h10,  1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
        vt[1] = v(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
        vt[2] = v(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b1, INS,   1'b0, 32'h0, 1'b0, 1'b0);
        vt[3] = v(1'b0, 32'h0,  1'b0, 1'b0, 32'h0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b0, INS,   1'b0, 32'h0, 1'b0, 1'b0);
        vt[4] = v(1'b0, 32'h0,  1'b1, 1'b1, 32'h100, BEEF,  1'b1, 1'b1, 32'h100, 1'b0, INS,   1'b0, 32'h0, 1'b0, 1'b1);
        vt[5] = v(1'b0, 32'h0,  1'b1, 1'b1, 32'h100, BEEF,  1'b0, 1'b0, 32'h0,   1'b0, INS,   1'b1, 32'h0, 1'b0, 1'b0);
        vt[6] = v(1'b0, 32'h0,  1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 1'b0, 32'h100, 1'b0, INS,   1'b0, 32'h0, 1'b0, 1'b1);
        vt[7] = v(1'b0, 32'h0,  1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0, 32'h0,   1'b0, INS,   1'b0, 32'h0, 1'b0, 1'b1);
        vt[8] = v(1'b0, 32'h0,  1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0, 32'h0,   1'b0, INS,   1'b1, BEEF,  1'b0, 1'b0);
        vt[9] = v(1'b0, 32'h0,  1'b0, 1'b0, 32'h0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b0, INS,   1'b0, BEEF,  1'b0, 1'b0);

        for (int u = 0; u < 2; u++) begin
            rst[u] = 1'b0; if_req[u] = 1'b0; if_addr[u] = '0; dm_req[u] = 1'b0;
            dm_we[u] = 1'b0; dm_addr[u] = '0; dm_wdata[u] = '0;
        end
        @(negedge clk);
        if_req[0] = 1'b1; if_addr[0] = 32'h10; dm_req[0] = 1'b1; dm_we[0] = 1'b1; dm_addr[0] = 32'h100;
        #1 chk_zero(0, "in reset");
        @(negedge clk);
        rst[0] = 1'b1; rst[1] = 1'b1; if_req[0] = 1'b0; dm_req[0] = 1'b0; dm_we[0] = 1'b0;
        #1 chk_zero(0, "after release");

        // fetch, then store + load to 0x100
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if_req[0] = vt[i].ifr; if_addr[0] = vt[i].ifa; dm_req[0] = vt[i].dmr;
            dm_we[0] = vt[i].dmw; dm_addr[0] = vt[i].dma; dm_wdata[0] = vt[i].dmd;
            #1;
            chk1($sformatf("vec%0d mem_en", i), mem_en[0], vt[i].en);
            if (vt[i].en) begin
                chk1($sformatf("vec%0d mem_we", i), mem_we[0], vt[i].we);
                chk32($sformatf("vec%0d mem_addr", i), mem_addr[0], vt[i].addr);
                if (vt[i].we) chk32($sformatf("vec%0d mem_wdata", i), mem_wdata[0], vt[i].dmd);
            end
            chk1($sformatf("vec%0d if_valid", i), if_valid[0], vt[i].ifv);
            chk32($sformatf("vec%0d if_rdata", i), if_rdata[0], vt[i].ifd);
            chk1($sformatf("vec%0d dm_valid", i), dm_valid[0], vt[i].dmv);
            chk32($sformatf("vec%0d dm_rdata", i), dm_rdata[0], vt[i].dmdat);
            chk1($sformatf("vec%0d stall_if", i), stall_if[0], vt[i].sif);
            chk1($sformatf("vec%0d stall_m", i), stall_m[0], vt[i].sm);
        end

        // both requesters held from reset: grants alternate DM, IF, ...
        @(negedge clk);
        rst[0] = 1'b0; if_req[0] = 1'b1; if_addr[0] = 32'h20;
        dm_req[0] = 1'b1; dm_we[0] = 1'b0; dm_addr[0] = 32'h40;
        @(negedge clk);
        rst[0] = 1'b1;
        run_if = 0; run_dm = 0; max_if = 0; max_dm = 0;
        for (int c = 0; c < 24; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (mem_en[0]) order.push_back(mem_addr[0]);
            run_if = stall_if[0] ? run_if + 1 : 0;
            run_dm = stall_m[0] ? run_dm + 1 : 0;
            if (run_if > max_if) max_if = run_if;
            if (run_dm > max_dm) max_dm = run_dm;
        end
        @(negedge clk);
        if_req[0] = 1'b0; dm_req[0] = 1'b0;
        chk32("tie issue count", 32'(order.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < order.size()) chk32($sformatf("tie grant%0d", i), order[i], (i % 2 == 0) ? 32'h40 : 32'h20);
        end
        chk32("tie max stall_if", 32'(max_if), 32'd5);
        chk32("tie max stall_m", 32'(max_dm), 32'd5);

        // reset during the second cycle of a read
        @(negedge clk);
        if_req[0] = 1'b1; if_addr[0] = 32'h10;
        #1 chk1("rstmid issue", mem_en[0], 1'b1);
        @(negedge clk);
        rst[0] = 1'b0;
        #1 chk_zero(0, "rstmid asserted");
        @(negedge clk);
        rst[0] = 1'b1; if_req[0] = 1'b0;
        #1;
        chk1("rstmid no late valid", if_valid[0], 1'b0);
        chk32("rstmid if_rdata", if_rdata[0], 32'h0);
        chk32("rstmid dm_rdata", dm_rdata[0], 32'h0);
        @(negedge clk);
        #1 chk1("rstmid still quiet", if_valid[0], 1'b0);
        @(negedge clk);
        if_req[0] = 1'b1;
        #1 chk1("rstmid reissue", mem_en[0], 1'b1);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk1("rstmid refetch valid", if_valid[0], 1'b1);
        chk32("rstmid refetch data", if_rdata[0], INS);

        // load flushed one cycle after issue, fetch waiting behind it
        @(negedge clk);
        if_req[0] = 1'b0; dm_req[0] = 1'b1; dm_we[0] = 1'b0; dm_addr[0] = 32'h100;
        #1 chk32("flush issue addr", mem_addr[0], 32'h100);
        @(negedge clk);
        dm_req[0] = 1'b0; if_req[0] = 1'b1; if_addr[0] = 32'h10;
        #1;
        chk1("flush mem_en idle", mem_en[0], 1'b0);
        chk1("flush stall_m", stall_m[0], 1'b0);
        chk1("flush stall_if", stall_if[0], 1'b1);
        @(negedge clk);
        #1;
        chk1("flush dm_valid", dm_valid[0], 1'b1);
        chk32("flush dm_rdata", dm_rdata[0], BEEF);
        @(negedge clk);
        #1;
        chk1("flush fetch issue", mem_en[0], 1'b1);
        chk32("flush fetch addr", mem_addr[0], 32'h10);
        @(negedge clk);
        @(negedge clk);
        #1 chk1("flush fetch valid", if_valid[0], 1'b1);
        @(negedge clk);
        if_req[0] = 1'b0;

        // MEM_LATENCY=1 back-to-back fetches
        @(negedge clk);
        if_req[1] = 1'b1; if_addr[1] = 32'h0;
        #1 chk1("lat1 issue0", mem_en[1], 1'b1);
        @(negedge clk);
        #1;
        chk1("lat1 valid0", if_valid[1], 1'b1);
        chk32("lat1 data0", if_rdata[1], 32'h0000_0013);
        @(negedge clk);
        if_addr[1] = 32'h4;
        #1;
        chk1("lat1 issue1", mem_en[1], 1'b1);
        chk1("lat1 gap valid", if_valid[1], 1'b0);
        chk32("lat1 gap hold", if_rdata[1], 32'h0000_0013);
        @(negedge clk);
        #1;
        chk1("lat1 valid1", if_valid[1], 1'b1);
        chk32("lat1 data1", if_rdata[1], 32'h0040_0113);
        @(negedge clk);
        if_req[1] = 1'b0;
        #1 chk32("lat1 hold1", if_rdata[1], 32'h0040_0113);

        run_random(0, 1500);
        run_random(1, 1500);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
